calc_top: RTL and testbench

- Small 5-bit, four-function sequential calculator: rotate, add, subtract, multiply.
- The host presents operands A and B and an OpCode, then raises OpCodeValid.
- The block returns a registered result on Z together with a one-cycle DataReady strobe.
- After reset it runs a short initialization phase, flagged on Initializing, during which requests are ignored.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_mul_seq.sv | 59 +++++
 rtl/calc_top.sv | 115 +++++++++++
 tb/tb_calc_top.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and default sizing for the 5-bit sequential calculator.
package calc_pkg;

    localparam int CALC_WIDTH       = 5;
    localparam int CALC_INIT_CYCLES = 4;

    typedef enum logic [1:0] {
        OP_ROT = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        EXEC,
        DONE
    } state_e;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// product truncated to WIDTH bits.
module calc_mul_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last    = r_busy && (r_cnt == LAST);

    // Done and product are presented on the final iteration so the caller
    // can register the result on the same edge the last bit is consumed.
    assign o_done    = w_last;
    assign o_product = w_acc_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last)
                r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_top.sv
// Four-function sequential calculator: rotate/add/sub in one cycle,
// multiply via the iterative shift-add unit; post-reset init phase.
module calc_top
    import calc_pkg::*;
#(
    parameter int WIDTH       = CALC_WIDTH,
    parameter int INIT_CYCLES = CALC_INIT_CYCLES
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OpCode,
    input  logic             OpCodeValid,
    output logic [WIDTH-1:0] Z,
    output logic             DataReady,
    output logic             Initializing
);

    localparam int               ICW       = $clog2(INIT_CYCLES + 1);
    localparam logic [ICW-1:0]   INIT_LAST = ICW'(INIT_CYCLES - 1);
    localparam logic [WIDTH-1:0] W_L       = WIDTH'(WIDTH);

    state_e             r_state;
    logic [ICW-1:0]     r_init_cnt;
    logic               r_vld_d;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    op_e                r_op;

    logic               w_req;
    logic [WIDTH-1:0]   w_sh;
    logic [2*WIDTH-1:0] w_rot2;
    logic [WIDTH-1:0]   w_alu;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [WIDTH-1:0]   w_mul_p;

    assign w_req       = OpCodeValid && !r_vld_d;
    assign w_mul_start = (r_state == IDLE) && w_req && (OpCode == OP_MUL);
    assign w_sh        = r_b % W_L;

    // Rotate via a doubled word: the upper half after the shift is the rotation.
    always_comb begin
        w_alu  = '0;
        w_rot2 = {r_a, r_a} << w_sh;
        case (r_op)
            OP_ROT:  w_alu = w_rot2[2*WIDTH-1:WIDTH];
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            default: w_alu = '0;
        endcase
    end

    calc_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .i_clk     (Clk),
        .i_rst_n   (Rst),
        .i_start   (w_mul_start),
        .i_a       (A),
        .i_b       (B),
        .o_done    (w_mul_done),
        .o_product (w_mul_p)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state      <= INIT;
            r_init_cnt   <= '0;
            r_vld_d      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= OP_ROT;
            Z            <= '0;
            DataReady    <= 1'b0;
            Initializing <= 1'b1;
        end else begin
            r_vld_d   <= OpCodeValid;
            DataReady <= 1'b0;
            case (r_state)
                INIT: begin
                    if (r_init_cnt == INIT_LAST) begin
                        r_state      <= IDLE;
                        Initializing <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_req) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= op_e'(OpCode);
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_op != OP_MUL) begin
                        Z         <= w_alu;
                        DataReady <= 1'b1;
                        r_state   <= DONE;
                    end else if (w_mul_done) begin
                        Z         <= w_mul_p;
                        DataReady <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_top.sv
// Self-checking bench for calc_top: directed spec vectors, wrap cases,
// handshake corner cases, reset abort, and random ops against a model.
module tb_calc_top;

    localparam int W = 5;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [1:0]   OpCode = '0;
    logic         OpCodeValid = 1'b0;
    logic [W-1:0] Z;
    logic         DataReady;
    logic         Initializing;

    int errors = 0;
    int checks = 0;

    calc_top dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .A            (A),
        .B            (B),
        .OpCode       (OpCode),
        .OpCodeValid  (OpCodeValid),
        .Z            (Z),
        .DataReady    (DataReady),
        .Initializing (Initializing)
    );

    always #50 Clk = ~Clk;

    function automatic logic [W-1:0] ref_z(input int a, input int b, input int op);
        int s;
        int r;
        case (op)
            0:       begin s = b % W; r = (a << s) | (a >> (W - s)); end
            1:       r = a + b;
            2:       r = a - b + (1 << W);
            default: r = a * b;
        endcase
        return W'(r % (1 << W));
    endfunction

    function automatic int ref_lat(input int op);
        return (op == 3) ? W : 1;
    endfunction

    // Issue one request, scramble inputs after capture, measure latency and pulse.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          output int lat, output logic [W-1:0] z, output logic dr_mid,
                          output logic [W-1:0] z_mid, output logic dr_after);
        @(negedge Clk);
        A = a; B = b; OpCode = op; OpCodeValid = 1'b1;
        @(negedge Clk);
        OpCodeValid = 1'b0;
        A = W'($urandom); B = W'($urandom); OpCode = 2'($urandom);
        dr_mid = DataReady;
        z_mid  = Z;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (DataReady) begin
                lat = k;
                break;
            end
        end
        z = Z;
        @(negedge Clk);
        dr_after = DataReady;
    endtask

    // Called right after Rst is released on a negedge.
    task automatic count_init(input bit pulse, output int n, output int dr);
        n = 0; dr = 0;
        for (int i = 0; i < 8; i++) begin
            if (pulse) OpCodeValid = (i == 0 || i >= 2);
            if (Initializing) n++;
            if (DataReady) dr++;
            @(negedge Clk);
        end
        OpCodeValid = 1'b0;
    endtask

    task automatic test_reset();
        int n, dr;
        repeat (2) @(negedge Clk);
        checks++; if (Z !== '0) begin errors++; $display("FAIL reset_z got=%0d want=0", Z); end
        checks++; if (DataReady !== 1'b0) begin errors++; $display("FAIL reset_dr got=%b want=0", DataReady); end
        checks++; if (Initializing !== 1'b1) begin errors++; $display("FAIL reset_init got=%b want=1", Initializing); end
        Rst = 1'b1;
        count_init(1'b1, n, dr);
        checks++; if (n !== 4) begin errors++; $display("FAIL init_cycles got=%0d want=4", n); end
        checks++; if (dr !== 0) begin errors++; $display("FAIL init_ignore_req got=%0d pulses want=0", dr); end
    endtask

    task automatic test_ops();
        logic [W-1:0] va [2] = '{5'd4, 5'd5};
        logic [W-1:0] vb [2] = '{5'd3, 5'd2};
        logic [W-1:0] ez [2][4] = '{'{5'd1, 5'd7, 5'd1, 5'd12}, '{5'd20, 5'd7, 5'd3, 5'd10}};
        int lat; logic [W-1:0] z, zm; logic dm, da;
        for (int s = 0; s < 2; s++) begin
            for (int op = 0; op < 4; op++) begin
                run_op(va[s], vb[s], 2'(op), lat, z, dm, zm, da);
                checks++; if (z !== ez[s][op]) begin errors++; $display("FAIL op_z a=%0d b=%0d op=%0d got=%0d want=%0d", va[s], vb[s], op, z, ez[s][op]); end
                checks++; if (lat !== ((op == 3) ? 5 : 1)) begin errors++; $display("FAIL op_lat op=%0d got=%0d want=%0d", op, lat, (op == 3) ? 5 : 1); end
                checks++; if (dm !== 1'b0 || da !== 1'b0) begin errors++; $display("FAIL op_pulse_width op=%0d before=%b after=%b want=0,0", op, dm, da); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] wa [3] = '{5'd3, 5'd8, 5'd31};
        logic [W-1:0] wb [3] = '{5'd4, 5'd5, 5'd1};
        logic [1:0]   wo [3] = '{2'd2, 2'd3, 2'd1};
        logic [W-1:0] wz [3] = '{5'd31, 5'd8, 5'd0};
        int lat; logic [W-1:0] z, zm; logic dm, da;
        for (int i = 0; i < 3; i++) begin
            run_op(wa[i], wb[i], wo[i], lat, z, dm, zm, da);
            checks++; if (z !== wz[i]) begin errors++; $display("FAIL wrap_z a=%0d b=%0d op=%0d got=%0d want=%0d", wa[i], wb[i], wo[i], z, wz[i]); end
        end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] z, zm, prev, exp; logic dm, da;
        logic [W-1:0] a, b; logic [1:0] op;
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); op = 2'($urandom);
            exp = ref_z(int'(a), int'(b), int'(op));
            run_op(a, b, op, lat, z, dm, zm, da);
            checks++; if (z !== exp) begin errors++; $display("FAIL rand_z a=%0d b=%0d op=%0d got=%0d want=%0d", a, b, op, z, exp); end
            checks++; if (lat !== ref_lat(int'(op))) begin errors++; $display("FAIL rand_lat op=%0d got=%0d want=%0d", op, lat, ref_lat(int'(op))); end
            checks++; if (zm !== prev) begin errors++; $display("FAIL rand_z_hold got=%0d want=%0d", zm, prev); end
            checks++; if (dm !== 1'b0 || da !== 1'b0) begin errors++; $display("FAIL rand_pulse before=%b after=%b want=0,0", dm, da); end
            prev = exp;
        end
    endtask

    task automatic test_hold_valid();
        int pulses = 0;
        logic [W-1:0] a = W'($urandom), b = W'($urandom), exp;
        exp = ref_z(int'(a), int'(b), 1);
        @(negedge Clk);
        A = a; B = b; OpCode = 2'd1; OpCodeValid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (i == 4) OpCodeValid = 1'b0;
            if (DataReady) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_valid_pulses got=%0d want=1", pulses); end
        checks++; if (Z !== exp) begin errors++; $display("FAIL hold_valid_z got=%0d want=%0d", Z, exp); end
    endtask

    task automatic test_drop_during_mul();
        int pulses = 0;
        @(negedge Clk);
        A = 5'd8; B = 5'd5; OpCode = 2'd3; OpCodeValid = 1'b1;
        @(negedge Clk);
        OpCodeValid = 1'b0;
        @(negedge Clk);
        A = 5'd1; B = 5'd1; OpCode = 2'd1; OpCodeValid = 1'b1;
        @(negedge Clk);
        OpCodeValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (DataReady) pulses++;
            @(negedge Clk);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_busy_pulses got=%0d want=1", pulses); end
        checks++; if (Z !== 5'd8) begin errors++; $display("FAIL drop_busy_z got=%0d want=8", Z); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, n, dr; logic [W-1:0] z, zm; logic dm, da;
        run_op(5'd3, 5'd4, 2'd1, lat, z, dm, zm, da);
        checks++; if (z !== 5'd7) begin errors++; $display("FAIL pre_reset_z got=%0d want=7", z); end
        @(negedge Clk);
        A = 5'd8; B = 5'd5; OpCode = 2'd3; OpCodeValid = 1'b1;
        @(negedge Clk);
        OpCodeValid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        checks++; if (Z !== '0) begin errors++; $display("FAIL midrst_z got=%0d want=0", Z); end
        checks++; if (Initializing !== 1'b1) begin errors++; $display("FAIL midrst_init got=%b want=1", Initializing); end
        @(negedge Clk);
        Rst = 1'b1;
        count_init(1'b0, n, dr);
        checks++; if (n !== 4) begin errors++; $display("FAIL midrst_init_cycles got=%0d want=4", n); end
        checks++; if (dr !== 0) begin errors++; $display("FAIL midrst_no_ready got=%0d want=0", dr); end
        checks++; if (Z !== '0) begin errors++; $display("FAIL midrst_z_after got=%0d want=0", Z); end
        run_op(5'd5, 5'd2, 2'd0, lat, z, dm, zm, da);
        checks++; if (z !== 5'd20) begin errors++; $display("FAIL midrst_recover_z got=%0d want=20", z); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_wrap();
        test_random();
        test_hold_valid();
        test_drop_during_mul();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
